exec_ctrl: RTL

Sequencing controller for the execute stage. It owns the ID/EX handoff and holds each instruction in the stage for its full latency: one cycle for ALU and branch ops, a variable number of cycles for FPU ops. It also inserts load-use bubbles, flushes on branch/jump miss, and holds results while the MEM stage is not ready. It sits between decode (valid/ready) and the exec datapath/MEM stage (valid/ready).

---
 rtl/exec_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/exec_ctrl.sv
// Execute-stage sequencing controller: ID/EX handoff, FPU wait with timeout,
// load-use bubble, branch/jump-miss flush and MEM backpressure hold.
//
// state      | meaning
// -----------+-------------------------------------------------------
// S_EMPTY    | no instruction in exec
// S_ALU      | single-cycle op in exec, result presented to MEM
// S_FPU_WAIT | FPU op running, waiting for ex_fin or timeout
// S_DONE     | FPU result presented to MEM
module exec_ctrl #(
  parameter int FPU_TIMEOUT = 64,
  parameter int RW          = 6
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          id_valid,
  output logic          id_ready,
  input  logic          id_is_fpu,
  input  logic [RW-1:0] id_rs0,
  input  logic [RW-1:0] id_rs1,
  input  logic          id_use_rs0,
  input  logic          id_use_rs1,
  output logic          ex_load,
  output logic          fpu_start,
  input  logic          ex_fin,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_regwrite,
  input  logic          ex_memread,
  input  logic          ex_branchjump_miss,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          flush,
  output logic          fpu_timeout_err,
  output logic [31:0]   stall_cycles
);

  localparam logic [1:0] S_EMPTY    = 2'd0;
  localparam logic [1:0] S_ALU      = 2'd1;
  localparam logic [1:0] S_FPU_WAIT = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  localparam int             CW       = $clog2(FPU_TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FPU_TIMEOUT - 1);

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_inc;
  logic          ld_pend;
  logic [RW-1:0] ld_rd;
  logic          presenting, hazard, can_issue, accept, timeout_hit;

  assign presenting   = (state == S_ALU) || (state == S_DONE);
  assign wait_cnt_inc = wait_cnt + CW'(1);

  // ld_pend only lives for the cycle right after a load completes
  assign hazard = ld_pend &&
                  ((id_use_rs0 && (id_rs0 == ld_rd)) ||
                   (id_use_rs1 && (id_rs1 == ld_rd)));

  assign flush       = presenting && out_ready && ex_branchjump_miss;
  assign can_issue   = id_valid && !hazard && !flush;
  assign out_valid   = presenting;
  assign ex_load     = id_ready;
  assign accept      = id_valid && id_ready;
  assign timeout_hit = (state == S_FPU_WAIT) && !ex_fin && (wait_cnt_inc == CNT_LAST);

  always_comb begin
    state_nxt = state;
    id_ready  = 1'b0;
    case (state)
      S_EMPTY: begin
        id_ready = can_issue;
        if (can_issue) state_nxt = id_is_fpu ? S_FPU_WAIT : S_ALU;
      end
      S_ALU, S_DONE: begin
        if (flush) begin
          state_nxt = S_EMPTY;
        end else if (out_ready) begin
          id_ready  = can_issue;
          state_nxt = can_issue ? (id_is_fpu ? S_FPU_WAIT : S_ALU) : S_EMPTY;
        end
      end
      S_FPU_WAIT: begin
        if (ex_fin || timeout_hit) state_nxt = S_DONE;
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= S_EMPTY;
      wait_cnt        <= '0;
      ld_pend         <= 1'b0;
      ld_rd           <= '0;
      fpu_start       <= 1'b0;
      fpu_timeout_err <= 1'b0;
      stall_cycles    <= '0;
    end else begin
      state     <= state_nxt;
      fpu_start <= accept && id_is_fpu;
      ld_pend   <= out_valid && out_ready && ex_memread && ex_regwrite && (ex_rd != '0);
      ld_rd     <= ex_rd;
      if (accept)
        wait_cnt <= '0;
      else if (state == S_FPU_WAIT)
        wait_cnt <= wait_cnt_inc;
      if (timeout_hit)
        fpu_timeout_err <= 1'b1;
      if (id_valid && !id_ready && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule
